// File: rtl/md_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide sequencer.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_e;

  function automatic logic isLongOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isMulOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; result is {hi, lo} for the given op.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  mdOp,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        divByZero
);

  logic signed [31:0] aS;
  logic signed [31:0] bS;
  logic signed [31:0] bSafeS;
  logic signed [31:0] qS;
  logic signed [31:0] rS;
  logic        [31:0] bSafeU;
  logic        [31:0] qU;
  logic        [31:0] rU;
  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic               divOvf;
  logic               bZero;

  assign aS    = a;
  assign bS    = b;
  assign bZero = (b == 32'd0);

  assign prodS = 64'(aS) * 64'(bS);
  assign prodU = 64'(a) * 64'(b);

  // Dividing by 1 reproduces the architectural result of 0x80000000 / -1
  // (quotient 0x80000000, remainder 0) without overflowing the divider.
  assign divOvf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign bSafeS = (bZero || divOvf) ? 32'sd1 : bS;
  assign bSafeU = bZero ? 32'd1 : b;

  assign qS = aS / bSafeS;
  assign rS = aS % bSafeS;
  assign qU = a / bSafeU;
  assign rU = a % bSafeU;

  assign divByZero = bZero && ((mdOp == MD_DIV) || (mdOp == MD_DIVU));

  always_comb begin
    res = '0;
    unique case (mdOp)
      MD_MULT:  res = prodS;
      MD_MULTU: res = prodU;
      MD_DIV:   res = {rS, qS};
      MD_DIVU:  res = {rU, qU};
      MD_NONE, MD_MTHI, MD_MTLO: res = '0;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle sequencer for the MD unit: holds Busy for the op latency, owns HI/LO.
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        StallReq,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdState_e          state;
  mdState_e          stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic [31:0]       hiReg;
  logic [31:0]       loReg;
  logic [31:0]       hiNext;
  logic [31:0]       loNext;
  logic [31:0]       pendHi;
  logic [31:0]       pendLo;
  logic [31:0]       pendHiNext;
  logic [31:0]       pendLoNext;
  logic              pendDbz;
  logic              pendDbzNext;
  logic              longStart;
  logic              commit;
  logic [63:0]       arithRes;
  logic              arithDbz;

  md_arith uArith (
    .mdOp      (MDOp),
    .a         (A),
    .b         (B),
    .res       (arithRes),
    .divByZero (arithDbz)
  );

  assign longStart = Start && isLongOp(MDOp);

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    pendHiNext  = pendHi;
    pendLoNext  = pendLo;
    pendDbzNext = pendDbz;
    hiNext      = hiReg;
    loNext      = loReg;
    commit      = 1'b0;

    case (state)
      IDLE: begin
        if (longStart) begin
          stateNext   = RUN;
          cntNext     = isMulOp(MDOp) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
          pendHiNext  = arithRes[63:32];
          pendLoNext  = arithRes[31:0];
          pendDbzNext = arithDbz;
        end
      end
      RUN: begin
        // A long op arriving here is a stall-unit bug and is dropped.
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          stateNext = IDLE;
          commit    = 1'b1;
        end
      end
    endcase

    if (commit && !pendDbz) begin
      hiNext = pendHi;
      loNext = pendLo;
    end

    // Moves to HI/LO take priority over a same-edge commit, per register.
    if (Start && (MDOp == MD_MTHI)) hiNext = A;
    if (Start && (MDOp == MD_MTLO)) loNext = A;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      pendHi  <= '0;
      pendLo  <= '0;
      pendDbz <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
      pendHi  <= pendHiNext;
      pendLo  <= pendLoNext;
      pendDbz <= pendDbzNext;
    end
  end

  assign Busy     = (state == RUN);
  assign StallReq = Busy | longStart;
  assign HI       = hiReg;
  assign LO       = loReg;

  illegalStartChk: assert property (@(posedge Clk) disable iff (!Reset)
    !(longStart && (state == RUN)))
    else $warning("md_sched: MD start ignored while busy");

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
Sequencer for the E-stage multiply/divide resource of the 5-stage MIPS pipeline.
- Accepts one mult/multu/div/divu/mthi/mtlo command per start pulse from E-stage control.
- Models the fixed multi-cycle latency of each operation and owns the HI/LO registers.
- Drives Busy into the stall unit, so that later MD instructions and mfhi/mflo are held in D until results commit.

Parameters:
MUL_LAT, 5, cycles Busy stays high for mult/multu (>=1)
DIV_LAT, 10, cycles Busy stays high for div/divu (>=1)

Ports:
Clk  input  1  pipeline clock, rising-edge
Reset  input  1  asynchronous, active-low; 0 clears all state immediately
Start  input  1  one-cycle pulse; the E-stage instruction is an MD op
MDOp  input  3  operation code (encoding below); sampled only when Start=1
A  input  32  forwarded rs value
B  input  32  forwarded rt value
Busy  output  1  operation in flight (registered)
StallReq  output  1  Busy | (Start & MDOp is mult/multu/div/divu); feeds the stall unit
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- MDOp encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and treated as NONE.
- Reset (Reset=0, asynchronous):
  - State=IDLE, Busy=0, counter=0.
  - HI=0, LO=0, pending result registers=0.
  - Reset applied mid-operation abandons the operation; no commit occurs.
- States: IDLE, RUN. A down-counter of width clog2(max(MUL_LAT,DIV_LAT)+1) is used.
- IDLE, Start with MULT/MULTU/DIV/DIVU, at the edge:
  - Compute the result combinationally from A/B and latch it into pending hi/lo.
  - Load counter with MUL_LAT or DIV_LAT, go to RUN, set Busy=1.
- RUN, each edge:
  - Counter decrements.
  - When counter==1 at the edge: HI/LO take the pending values, Busy=0, go to IDLE.
  - Net effect: Busy is high for exactly LAT cycles after the Start edge, and the new HI/LO are visible in the first cycle Busy=0.
- MTHI / MTLO (Start=1, any state):
  - HI (or LO) takes A at the next edge; single cycle, never asserts Busy.
  - An MTHI/MTLO in the same edge as a RUN commit wins over the commit for its register only.
- Start with MULT..DIVU while in RUN is illegal (the stall unit must prevent it).
  - Command is ignored; the current operation continues unchanged.
  - Simulation assertion flags it.
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit product; HI=[63:32], LO=[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero (B==0): full DIV_LAT busy period still occurs; HI and LO are left unchanged at commit.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0 (no trap).
- StallReq is combinational from Start/MDOp and the registered Busy; no combinational path from A/B to any output.
- HI/LO outputs hold their old values throughout RUN.

Decomposition:
- Shared package md_pkg holds:
  - MDOp encoding constants.
  - Default MUL_LAT/DIV_LAT.
  - State encoding (IDLE=0, RUN=1).
- The combinational arithmetic is split into one sub-module, md_arith (inputs MDOp/A/B; outputs 64-bit {hi,lo} and a div_by_zero flag).
- Counter and FSM stay in md_sched.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 at cycle 0 -> Busy=1 for cycles 1-5; at cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- DIVU A=100, B=7 -> Busy for 10 cycles, then LO=14, HI=2; DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> Busy 10 cycles; afterwards HI=0x11, LO=0x22.
- MTLO A=0xABCD issued on the commit edge of MULTU 0x10000*0x10000 -> HI=0x1, LO=0xABCD.
- Start=1 with MDOp=MULT, StallReq=1 in the same cycle; second MULT pulsed during RUN -> ignored, assertion fires, original result commits.
- Reset driven low at cycle 3 of a DIV -> Busy, HI, LO are 0 immediately (before the next edge); after release, a fresh MULT 2*3 gives LO=6 after 5 cycles.
